// File: rtl/lstm_pkg.sv
// Shared LSTM buffer-path definitions: default vector geometry and the
// 2-bit state encoding used by both the serializer and deserializer FSMs.
package lstm_pkg;

  localparam int LSTM_ELEMENT_BITS = 8;
  localparam int LSTM_FEATURES     = 4;
  localparam int LSTM_FEATURE_BITS = 3;

  typedef logic [1:0] lstm_state_t;

  localparam lstm_state_t ST_IDLE  = 2'd0;
  localparam lstm_state_t ST_READ  = 2'd1;
  localparam lstm_state_t ST_DRAIN = 2'd2;
  localparam lstm_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/lstm_deserializer.sv
// Gathers FEATURES elements from a 1-cycle-latency buffer into one vector; FEATURES+2 cycles
// from start to done. No backpressure: start is honoured only in IDLE, never queued.
module lstm_deserializer
  import lstm_pkg::*;
#(
  parameter int ELEMENT_BITS = LSTM_ELEMENT_BITS,
  parameter int FEATURES     = LSTM_FEATURES,
  parameter int FEATURE_BITS = LSTM_FEATURE_BITS
) (
  input  logic                             sys_clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [FEATURE_BITS-1:0]          base_addr,
  output logic                             rd_en,
  output logic [FEATURE_BITS-1:0]          rd_addr,
  input  logic [ELEMENT_BITS-1:0]          rd_data,
  output logic [FEATURES*ELEMENT_BITS-1:0] parallel_data_out,
  output logic                             busy,
  output logic                             done
);

  localparam logic [FEATURE_BITS-1:0] LAST_IDX = FEATURE_BITS'(FEATURES - 1);

  lstm_state_t                              state_q, state_d;
  logic [FEATURE_BITS-1:0]                  base_q, base_d;
  logic [FEATURE_BITS-1:0]                  issue_cnt_q, issue_cnt_d;
  logic [FEATURE_BITS-1:0]                  cap_cnt_q, cap_cnt_d;
  logic                                     cap_vld_q, cap_vld_d;
  logic [FEATURES-1:0][ELEMENT_BITS-1:0]    shadow_q, shadow_d;
  logic [FEATURES-1:0][ELEMENT_BITS-1:0]    pdo_q, pdo_d;

  assign rd_en             = (state_q == ST_READ);
  assign rd_addr           = rd_en ? (base_q + issue_cnt_q) : '0;
  assign busy              = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done              = (state_q == ST_DONE);
  assign parallel_data_out = pdo_q;
  assign cap_vld_d         = rd_en;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    shadow_d    = shadow_q;
    pdo_d       = pdo_q;

    // Read data trails the strobe by one cycle, so capture keys off the delayed strobe only.
    if (cap_vld_q) begin
      for (int i = 0; i < FEATURES; i++) begin
        if (cap_cnt_q == FEATURE_BITS'(i)) begin
          shadow_d[i] = rd_data;
        end
      end
      cap_cnt_d = cap_cnt_q + FEATURE_BITS'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_READ;
          base_d      = base_addr;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
          shadow_d    = '0;
        end
      end
      ST_READ: begin
        issue_cnt_d = issue_cnt_q + FEATURE_BITS'(1);
        if (issue_cnt_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The final element lands this cycle; publish it together with the rest.
        pdo_d   = shadow_d;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      cap_vld_q   <= 1'b0;
      shadow_q    <= '0;
      pdo_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      cap_vld_q   <= cap_vld_d;
      shadow_q    <= shadow_d;
      pdo_q       <= pdo_d;
    end
  end

endmodule

// File: tb/tb_lstm_deserializer.sv
// Bench for lstm_deserializer: buffer model, gather-window reference model and scoreboard monitor.
module tb_lstm_deserializer;

  localparam int EB    = 8;
  localparam int NF    = 4;
  localparam int FB    = 3;
  localparam int DEPTH = 8;

  logic                 sys_clk = 1'b0;
  logic                 reset_n = 1'b1;
  logic                 start = 1'b0;
  logic [FB-1:0]        base_addr = '0;
  logic                 rd_en;
  logic [FB-1:0]        rd_addr;
  logic [EB-1:0]        rd_data = 'x;
  logic [NF*EB-1:0]     parallel_data_out;
  logic                 busy;
  logic                 done;

  always #5 sys_clk = ~sys_clk;

  lstm_deserializer #(.ELEMENT_BITS(EB), .FEATURES(NF), .FEATURE_BITS(FB)) dut (
    .sys_clk           (sys_clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .parallel_data_out (parallel_data_out),
    .busy              (busy),
    .done              (done)
  );

  // Buffer: data valid only in the cycle after a strobe, unknown otherwise.
  logic [EB-1:0] mem [DEPTH];
  always @(posedge sys_clk) rd_data <= rd_en ? mem[rd_addr] : 'x;

  int edge_no = 0;
  always @(posedge sys_clk) edge_no <= edge_no + 1;

  typedef struct { int e; logic [FB-1:0] a; } rd_exp_t;
  typedef struct { int e; logic [NF*EB-1:0] v; } dn_exp_t;
  rd_exp_t rd_q[$];
  dn_exp_t dn_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int next_free = 0;
  int active_t  = -100;
  logic [NF*EB-1:0] held = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
  endtask

  // A gather accepted at edge e reads base+i during intervals e..e+NF-1, signals done in
  // interval e+NF+1 and frees the block for a new start from edge e+NF+3 onwards.
  task automatic step(input logic s, input logic [FB-1:0] b);
    int e;
    rd_exp_t r;
    dn_exp_t d;
    @(negedge sys_clk); #1;
    start = s;
    base_addr = b;
    e = edge_no + 1;
    if (s && reset_n && e >= next_free) begin
      d.v = '0;
      for (int i = 0; i < NF; i++) begin
        r.e = e + i;
        r.a = FB'((int'(b) + i) % DEPTH);
        rd_q.push_back(r);
        d.v[i*EB +: EB] = mem[r.a];
      end
      d.e = e + NF + 1;
      dn_q.push_back(d);
      active_t  = e;
      next_free = e + NF + 3;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pdo"}, parallel_data_out, 0);
  endtask

  task automatic mid_reset();
    @(negedge sys_clk); #1;
    start = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    rd_q.delete();
    dn_q.delete();
    active_t  = -100;
    next_free = 0;
    held      = '0;
    @(negedge sys_clk); #1;
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    rd_exp_t r;
    dn_exp_t d;
    logic    busy_exp;
    forever begin
      @(negedge sys_clk);
      busy_exp = (edge_no >= active_t) && (edge_no <= active_t + NF);
      check("busy", busy, busy_exp);
      if (rd_en) begin
        if (rd_q.size() == 0) check("rd_en_spurious", rd_en, 0);
        else begin
          r = rd_q.pop_front();
          check("rd_edge", edge_no, r.e);
          check("rd_addr", rd_addr, r.a);
        end
      end else if (rd_q.size() != 0 && rd_q[0].e <= edge_no) begin
        check("rd_en_missing", rd_en, 1);
        void'(rd_q.pop_front());
      end
      if (done) begin
        if (dn_q.size() == 0) check("done_spurious", done, 0);
        else begin
          d = dn_q.pop_front();
          check("done_edge", edge_no, d.e);
          check("vec", parallel_data_out, d.v);
          held = d.v;
        end
      end else begin
        if (dn_q.size() != 0 && dn_q[0].e <= edge_no) begin
          check("done_missing", done, 1);
          held = dn_q[0].v;
          void'(dn_q.pop_front());
        end
        check("pdo_hold", parallel_data_out, held);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = EB'((i + 1) * 8'h11);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst");
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // Plain gathers, including one whose addresses wrap past the top of the buffer.
    step(1'b1, 3'd0); idle(8);
    step(1'b1, 3'd4); idle(8);
    step(1'b1, 3'd6); idle(8);

    // Extra starts during READ and during DONE must be dropped.
    step(1'b1, 3'd1);
    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    step(1'b1, 3'd5);
    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    step(1'b1, 3'd3);
    idle(8);

    // Start held high: back-to-back gathers.
    for (int i = 0; i < 20; i++) step(1'b1, FB'($urandom_range(0, DEPTH - 1)));
    idle(8);

    // Reset after two reads, then a full gather that must not carry stale elements.
    step(1'b1, 3'd2);
    step(1'b0, 3'd0);
    mid_reset();
    idle(2);
    step(1'b1, 3'd5); idle(8);

    // Randomized traffic over fresh buffer contents.
    for (int i = 0; i < DEPTH; i++) mem[i] = EB'($urandom_range(0, 255));
    idle(2);
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) == 0), FB'($urandom_range(0, DEPTH - 1)));
    idle(12);

    check("rd_q_drained", rd_q.size(), 0);
    check("dn_q_drained", dn_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
